qos_reader: RTL and testbench
=============================

Name: qos_reader

Overview:
- Read-side consumer for the qos buffer block.
- Watches per-class FIFO empty flags and picks a class by weighted round robin.
- Issues a single-cycle read strobe with a class select, captures the returned byte and forwards it downstream over a valid/ready handshake.
- Keeps a per-class count of delivered words, readable through a request/response port.

Parameters:
- NCLASS, 4, number of qos FIFO classes; a power of 2, at least 2.
- SELW, 2, select width; equals log2(NCLASS).
- DW, 8, data width; matches DATA_OUT of qos.
- WW, 3, per-class weight width.
- CW, 8, per-class delivered-word counter width.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- init  in  1  one-cycle pulse; latches WEIGHTS, reloads credits, clears counters.
- WEIGHTS  in  NCLASS*WW  class i weight in bits [i*WW +: WW].
- FIFO_EMPTY  in  NCLASS  per-class empty flag from qos.
- read  out  1  read strobe to qos.
- RD_SEL  out  SELW  class being read; valid while read=1.
- DATA_OUT  in  DW  byte from qos; valid exactly one cycle after read.
- OUT_DATA  out  DW  forwarded byte.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_READY  in  1  downstream accepts.
- OUT_CLASS  out  SELW  class of OUT_DATA.
- CNT_REQ  in  1  counter read request.
- CNT_IDX  in  SELW  class to report.
- CNT_VALID  out  1  one-cycle response strobe.
- CNT_DATA  out  CW  reported count.

Behaviour:
- Reset (asynchronous, RESET=1): all outputs 0.
  - State UNINIT; weights 0; credits 0; counters 0; round-robin pointer 0.
- FSM states: UNINIT, ARB, RELOAD, READ, CAPTURE, HOLD.
- UNINIT
  - No reads; waits for init=1.
  - On init: weight[i] = WEIGHTS slice; a weight of 0 is stored as 1.
  - Also: credit[i] = weight[i]; counters cleared; go to ARB.
- ARB
  - Scan classes from ptr+1 (modulo NCLASS) for the first one that is non-empty and has credit>0. If found, sel = that class; go to READ.
  - Else if any class is non-empty: go to RELOAD.
  - Else: stay in ARB.
- RELOAD: credit[i] = weight[i] for all i; go to ARB. No read in this cycle.
- READ
  - read=1 and RD_SEL=sel for exactly one cycle.
  - credit[sel] decrements by 1; ptr = sel; go to CAPTURE.
  - FIFO_EMPTY is only sampled in ARB; it is not rechecked here.
- CAPTURE
  - OUT_DATA <= DATA_OUT, OUT_CLASS <= sel, OUT_VALID <= 1.
  - count[sel] increments, saturating at 2^CW-1.
  - Go to HOLD.
- HOLD
  - Hold OUT_DATA, OUT_CLASS and OUT_VALID stable while OUT_READY=0.
  - When OUT_VALID & OUT_READY: OUT_VALID <= 0 next cycle; go to ARB.
- Throughput: best case 1 word per 4 cycles (ARB, READ, CAPTURE, HOLD with OUT_READY=1). Reader-added latency from read to OUT_VALID is 2 cycles; add 1 more cycle when the first candidate needs a RELOAD.
- init outside UNINIT
  - Accepted only in ARB or RELOAD: same effect as from UNINIT.
  - Ignored in READ, CAPTURE and HOLD, so an in-flight word is never lost.
- Counter port
  - CNT_REQ=1 in cycle t gives CNT_VALID=1 in cycle t+1 for one cycle, with CNT_DATA = count[CNT_IDX] as sampled at t.
  - If CAPTURE increments the same class in cycle t, the pre-increment value is reported.
  - Back-to-back requests are honoured every cycle.
  - CNT_DATA returns to 0 when CNT_VALID=0.
- Reset mid-operation: an immediate return to reset values. A byte held in HOLD is discarded.

Decomposition:
- Shared package qos_pkg holds:
  - state encoding constants (UNINIT=0 … HOLD=5);
  - default DW, NCLASS and SELW, shared with qos and tester.
- One natural sub-module: qos_rr_arbiter.
  - Combinational rotating-priority pick.
  - Inputs: eligible vector = ~FIFO_EMPTY & (credit!=0), and ptr.
  - Outputs: grant_valid, grant_idx.
- The FSM, credits, counters and output register stay in qos_reader.

Test Plan:
- Reset/init: RESET pulse, then init with weights 1,1,1,1 and all FIFOs empty -> read never asserted; CNT_REQ for idx 2 -> CNT_VALID next cycle with CNT_DATA=0.
- Single class: class 1 non-empty, DATA_OUT=0xA5 after read, OUT_READY=1 -> read with RD_SEL=1, then OUT_VALID with OUT_DATA=0xA5 and OUT_CLASS=1 two cycles later; count[1]=1.
- Weighted round robin: weights 3,1,0,0, classes 0 and 1 always non-empty, 12 words drained -> class order 0,1,0,0,RELOAD,... giving class 0 = 9 words and class 1 = 3 words (3:1).
- Backpressure: OUT_READY=0 for 5 cycles in HOLD -> OUT_DATA stable, no read issued; OUT_READY=1 -> next read 2 cycles later.
- Counter collision: CNT_REQ idx 0 in the same cycle CAPTURE increments class 0 from 4 -> CNT_DATA=4; a repeat request -> 5. Saturation with CW=8 after 300 words -> 255.
- Mid-op reset: RESET asserted during HOLD -> OUT_VALID=0 immediately (asynchronously); after release, state UNINIT and no read until init.

Source files
------------

// File: rtl/qos_pkg.sv
// Shared definitions for the qos buffer, its reader and tester.
package qos_pkg;

   localparam int QOS_NCLASS = 4;
   localparam int QOS_SELW   = 2;
   localparam int QOS_DW     = 8;

   typedef enum logic [2:0] {
      UNINIT  = 3'd0,
      ARB     = 3'd1,
      RELOAD  = 3'd2,
      READ    = 3'd3,
      CAPTURE = 3'd4,
      HOLD    = 3'd5
   } state_e;

endpackage

// File: rtl/qos_reader_if.sv
// Reader-side bundle: qos FIFO read port, downstream stream, counter port, config.
interface qos_reader_if
   import qos_pkg::*;
#(
   parameter int NCLASS = QOS_NCLASS,
   parameter int SELW   = QOS_SELW,
   parameter int DW     = QOS_DW,
   parameter int WW     = 3,
   parameter int CW     = 8
);
   logic                 init;
   logic [NCLASS*WW-1:0] WEIGHTS;
   logic [NCLASS-1:0]    FIFO_EMPTY;
   logic                 read;
   logic [SELW-1:0]      RD_SEL;
   logic [DW-1:0]        DATA_OUT;
   logic [DW-1:0]        OUT_DATA;
   logic                 OUT_VALID;
   logic                 OUT_READY;
   logic [SELW-1:0]      OUT_CLASS;
   logic                 CNT_REQ;
   logic [SELW-1:0]      CNT_IDX;
   logic                 CNT_VALID;
   logic [CW-1:0]        CNT_DATA;

   modport master (
      input  init, WEIGHTS, FIFO_EMPTY, DATA_OUT, OUT_READY, CNT_REQ, CNT_IDX,
      output read, RD_SEL, OUT_DATA, OUT_VALID, OUT_CLASS, CNT_VALID, CNT_DATA
   );

   modport slave (
      output init, WEIGHTS, FIFO_EMPTY, DATA_OUT, OUT_READY, CNT_REQ, CNT_IDX,
      input  read, RD_SEL, OUT_DATA, OUT_VALID, OUT_CLASS, CNT_VALID, CNT_DATA
   );

endinterface

// File: rtl/qos_rr_arbiter.sv
// Rotating-priority pick: first eligible class starting after ptr, wrapping to ptr itself.
module qos_rr_arbiter #(
   parameter int NCLASS = 4,
   parameter int SELW   = 2
) (
   input  logic [NCLASS-1:0] eligible,
   input  logic [SELW-1:0]   ptr,
   output logic              grant_valid,
   output logic [SELW-1:0]   grant_idx
);

   logic [SELW-1:0] cand;

   // Walk from the farthest offset down so the nearest eligible class wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = NCLASS; k >= 1; k--) begin
         cand = ptr + SELW'(k);
         if (eligible[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/qos_reader.sv
// Weighted round-robin reader for the qos FIFOs with per-class delivered-word counters.
// UNINIT wait init | ARB pick class | RELOAD refill credits | READ strobe | CAPTURE take byte | HOLD offer downstream
module qos_reader
   import qos_pkg::*;
#(
   parameter int NCLASS = QOS_NCLASS,
   parameter int SELW   = QOS_SELW,
   parameter int DW     = QOS_DW,
   parameter int WW     = 3,
   parameter int CW     = 8
) (
   input logic          CLK,
   input logic          RESET,
   qos_reader_if.master bus
);

   state_e            state_q, state_d;
   logic [WW-1:0]     weight_q [NCLASS];
   logic [WW-1:0]     weight_d [NCLASS];
   logic [WW-1:0]     credit_q [NCLASS];
   logic [WW-1:0]     credit_d [NCLASS];
   logic [CW-1:0]     count_q  [NCLASS];
   logic [CW-1:0]     count_d  [NCLASS];
   logic [SELW-1:0]   ptr_q, ptr_d;
   logic [SELW-1:0]   sel_q, sel_d;
   logic [DW-1:0]     out_data_q, out_data_d;
   logic [SELW-1:0]   out_class_q, out_class_d;
   logic              out_valid_q, out_valid_d;
   logic              cnt_valid_q, cnt_valid_d;
   logic [CW-1:0]     cnt_data_q, cnt_data_d;

   logic [NCLASS-1:0] eligible;
   logic              grant_valid;
   logic [SELW-1:0]   grant_idx;
   logic              init_ok;
   logic              rd;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NCLASS; i++) begin
         eligible[i] = ~bus.FIFO_EMPTY[i] & (credit_q[i] != '0);
      end
   end

   qos_rr_arbiter #(.NCLASS(NCLASS), .SELW(SELW)) u_arb (
      .eligible    (eligible),
      .ptr         (ptr_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_comb begin
      state_d     = state_q;
      weight_d    = weight_q;
      credit_d    = credit_q;
      count_d     = count_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      out_data_d  = out_data_q;
      out_class_d = out_class_q;
      out_valid_d = out_valid_q;
      init_ok     = bus.init && (state_q == UNINIT || state_q == ARB || state_q == RELOAD);

      unique case (state_q)
         UNINIT: ;
         ARB: begin
            if (grant_valid) begin
               sel_d   = grant_idx;
               state_d = READ;
            end else if ((~bus.FIFO_EMPTY) != '0) begin
               state_d = RELOAD;
            end
         end
         RELOAD: begin
            credit_d = weight_q;
            state_d  = ARB;
         end
         READ: begin
            credit_d[sel_q] = credit_q[sel_q] - WW'(1);
            ptr_d           = sel_q;
            state_d         = CAPTURE;
         end
         CAPTURE: begin
            out_data_d  = bus.DATA_OUT;
            out_class_d = sel_q;
            out_valid_d = 1'b1;
            if (count_q[sel_q] != '1) count_d[sel_q] = count_q[sel_q] + CW'(1);
            state_d = HOLD;
         end
         HOLD: begin
            if (out_valid_q && bus.OUT_READY) begin
               out_valid_d = 1'b0;
               state_d     = ARB;
            end
         end
         default: state_d = UNINIT;
      endcase

      // Init is refused while a word is in flight so nothing gets dropped.
      if (init_ok) begin
         for (int i = 0; i < NCLASS; i++) begin
            weight_d[i] = (bus.WEIGHTS[i*WW +: WW] == '0) ? WW'(1) : bus.WEIGHTS[i*WW +: WW];
            credit_d[i] = weight_d[i];
            count_d[i]  = '0;
         end
         state_d = ARB;
      end
   end

   always_comb begin
      cnt_valid_d = bus.CNT_REQ;
      cnt_data_d  = bus.CNT_REQ ? count_q[bus.CNT_IDX] : '0;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= UNINIT;
         ptr_q       <= '0;
         sel_q       <= '0;
         out_data_q  <= '0;
         out_class_q <= '0;
         out_valid_q <= 1'b0;
         cnt_valid_q <= 1'b0;
         cnt_data_q  <= '0;
         for (int i = 0; i < NCLASS; i++) begin
            weight_q[i] <= '0;
            credit_q[i] <= '0;
            count_q[i]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         out_data_q  <= out_data_d;
         out_class_q <= out_class_d;
         out_valid_q <= out_valid_d;
         cnt_valid_q <= cnt_valid_d;
         cnt_data_q  <= cnt_data_d;
         weight_q    <= weight_d;
         credit_q    <= credit_d;
         count_q     <= count_d;
      end
   end

   assign rd            = (state_q == READ);
   assign bus.read      = rd;
   assign bus.RD_SEL    = rd ? sel_q : '0;
   assign bus.OUT_DATA  = out_data_q;
   assign bus.OUT_CLASS = out_class_q;
   assign bus.OUT_VALID = out_valid_q;
   assign bus.CNT_VALID = cnt_valid_q;
   assign bus.CNT_DATA  = cnt_data_q;

endmodule

// File: tb/tb_qos_reader.sv
// Randomized bench for qos_reader: queue-based FIFO source, WRR reference model, stream and counter scoreboards.
module tb_qos_reader;
   import qos_pkg::*;

   localparam int NC = 4;
   localparam int SW = 2;
   localparam int DW = 8;
   localparam int WW = 3;
   localparam int CW = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   qos_reader_if #(.NCLASS(NC), .SELW(SW), .DW(DW), .WW(WW), .CW(CW)) bus ();

   qos_reader #(.NCLASS(NC), .SELW(SW), .DW(DW), .WW(WW), .CW(CW)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [7:0] fq [NC][$];
   logic [7:0] exp_data [$];
   int         exp_cls  [$];

   int  mw [NC];
   int  mcred [NC];
   int  mcnt [NC];
   int  mptr;
   bit  uninit;
   bit  cnt_pend;
   int  cnt_exp;
   int  cnt_mode;
   int  cnt_fix;
   int  ready_mode;
   bit  inc_pend;
   int  inc_cls;
   bit  live;
   bit  hold_pend;
   logic [7:0] hold_data;
   int  hold_cls;
   int  last_rd_cyc;
   bit  hs_flag;
   int  hs_cyc;
   int  out_words;
   int  tally [NC];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NC; i++) if (fq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic upd_flags();
      for (int i = 0; i < NC; i++) bus.FIFO_EMPTY[i] = (fq[i].size() == 0);
   endtask

   task automatic model_reset();
      mptr = 0;
      for (int i = 0; i < NC; i++) begin
         mw[i] = 0; mcred[i] = 0; mcnt[i] = 0;
      end
      uninit = 1; cnt_pend = 0; inc_pend = 0; hold_pend = 0;
      hs_flag = 0; live = 0;
      exp_data.delete();
      exp_cls.delete();
   endtask

   // Weighted round robin from the rules: scan after ptr, refill credits if nobody qualifies.
   task automatic model_pick(output int c, output bit rl);
      int j;
      c  = -1;
      rl = 0;
      for (int pass = 0; pass < 2; pass++) begin
         if (c < 0) begin
            for (int k = 1; k <= NC; k++) begin
               j = (mptr + k) % NC;
               if (c < 0 && fq[j].size() > 0 && mcred[j] > 0) c = j;
            end
            if (c < 0 && pass == 0) begin
               for (int i = 0; i < NC; i++) mcred[i] = mw[i];
               rl = 1;
            end
         end
      end
   endtask

   task automatic reset_checks();
      check("rst_read", bus.read, 0);
      check("rst_rd_sel", bus.RD_SEL, 0);
      check("rst_out_valid", bus.OUT_VALID, 0);
      check("rst_out_data", bus.OUT_DATA, 0);
      check("rst_out_class", bus.OUT_CLASS, 0);
      check("rst_cnt_valid", bus.CNT_VALID, 0);
      check("rst_cnt_data", bus.CNT_DATA, 0);
   endtask

   task automatic step();
      int  idx;
      int  c;
      bit  rl;
      logic [7:0] b;
      @(negedge clk);
      bus.init = 1'b0;

      if (cnt_pend) begin
         check("cnt_valid", bus.CNT_VALID, 1);
         check("cnt_data", bus.CNT_DATA, cnt_exp);
      end else begin
         check("cnt_valid_idle", bus.CNT_VALID, 0);
         check("cnt_data_idle", bus.CNT_DATA, 0);
      end

      if (hold_pend) begin
         check("hold_valid", bus.OUT_VALID, 1);
         check("hold_data", bus.OUT_DATA, hold_data);
         check("hold_class", bus.OUT_CLASS, hold_cls);
      end
      check("read_in_hold", bus.read & bus.OUT_VALID, 0);

      case (ready_mode)
         0:       bus.OUT_READY = 1'b0;
         1:       bus.OUT_READY = 1'b1;
         default: bus.OUT_READY = 1'($urandom_range(0, 1));
      endcase

      if (bus.OUT_VALID && !hold_pend) begin
         if (exp_data.size() == 0) begin
            check("unexpected_out", 1, 0);
         end else begin
            check("out_latency", cyc - last_rd_cyc, 2);
            check("out_data", bus.OUT_DATA, exp_data[0]);
            check("out_class", bus.OUT_CLASS, exp_cls[0]);
            tally[bus.OUT_CLASS]++;
            out_words++;
            void'(exp_data.pop_front());
            void'(exp_cls.pop_front());
         end
      end
      hold_pend = bus.OUT_VALID && !bus.OUT_READY;
      hold_data = bus.OUT_DATA;
      hold_cls  = int'(bus.OUT_CLASS);
      if (bus.OUT_VALID && bus.OUT_READY) begin
         hs_cyc  = cyc;
         hs_flag = !all_empty();
      end

      cnt_pend    = 0;
      bus.CNT_REQ = 1'b0;
      bus.CNT_IDX = SW'($urandom);
      if (cnt_mode == 2 || (cnt_mode == 1 && $urandom_range(0, 2) == 0)) begin
         idx         = (cnt_mode == 2) ? cnt_fix : int'($urandom_range(0, NC - 1));
         bus.CNT_REQ = 1'b1;
         bus.CNT_IDX = SW'(idx);
         cnt_pend    = 1;
         cnt_exp     = mcnt[idx];
      end

      if (inc_pend) begin
         if (mcnt[inc_cls] < CMAX) mcnt[inc_cls]++;
         inc_pend = 0;
      end

      if (bus.read) begin
         c = -1;
         if (uninit || all_empty()) begin
            check("spurious_read", 1, 0);
         end else begin
            model_pick(c, rl);
            if (c < 0) check("model_no_pick", 1, 0);
         end
         if (c >= 0) begin
            check("rd_sel", bus.RD_SEL, c);
            if (hs_flag && !rl) check("rd_gap", cyc - hs_cyc, 2);
            b = fq[c].pop_front();
            bus.DATA_OUT = b;
            live = 1;
            exp_data.push_back(b);
            exp_cls.push_back(c);
            inc_pend = 1;
            inc_cls  = c;
            mcred[c]--;
            mptr = c;
         end else begin
            bus.DATA_OUT = DW'($urandom);
         end
         hs_flag     = 0;
         last_rd_cyc = cyc;
      end else if (live) begin
         live = 0;
      end else begin
         bus.DATA_OUT = DW'($urandom);
      end

      upd_flags();
      cyc++;
   endtask

   task automatic do_init(input logic [NC*WW-1:0] w);
      int s;
      bus.WEIGHTS = w;
      bus.init    = 1'b1;
      for (int i = 0; i < NC; i++) begin
         s        = int'((w >> (i * WW)) & 3'h7);
         mw[i]    = (s == 0) ? 1 : s;
         mcred[i] = mw[i];
         mcnt[i]  = 0;
      end
      uninit  = 0;
      hs_flag = 0;
      step();
   endtask

   task automatic push(input int c, input int n);
      for (int i = 0; i < n; i++) fq[c].push_back(8'($urandom));
      upd_flags();
   endtask

   task automatic drain(input int limit);
      bit done;
      done = 0;
      for (int n = 0; n < limit; n++) begin
         if (!done) begin
            if (all_empty() && exp_data.size() == 0 && !bus.OUT_VALID) done = 1;
            else step();
         end
      end
      if (!done) check("drain_timeout", 0, 1);
      repeat (3) step();
   endtask

   task automatic wait_valid(input int limit);
      bit seen;
      seen = 0;
      for (int n = 0; n < limit; n++) begin
         if (!seen) begin
            if (bus.OUT_VALID) seen = 1;
            else step();
         end
      end
      if (!seen) check("valid_timeout", 0, 1);
   endtask

   initial begin
      bus.init       = 1'b0;
      bus.WEIGHTS    = '0;
      bus.FIFO_EMPTY = '1;
      bus.DATA_OUT   = '0;
      bus.OUT_READY  = 1'b0;
      bus.CNT_REQ    = 1'b0;
      bus.CNT_IDX    = '0;
      cnt_mode = 0; cnt_fix = 0; ready_mode = 1;
      last_rd_cyc = 0; hs_cyc = 0; out_words = 0;
      for (int i = 0; i < NC; i++) tally[i] = 0;
      model_reset();

      // Reset, init with empty FIFOs, counter read of idx 2
      #2 reset_checks();
      @(negedge clk);
      rst = 1'b0;
      repeat (5) step();
      do_init({NC{3'd1}});
      cnt_mode = 2; cnt_fix = 2;
      repeat (10) step();

      // Single word on class 1
      cnt_fix = 1;
      fq[1].push_back(8'hA5);
      upd_flags();
      drain(50);
      cnt_mode = 0;

      // Weighted round robin 3:1
      do_init({3'd0, 3'd0, 3'd1, 3'd3});
      for (int i = 0; i < NC; i++) tally[i] = 0;
      out_words = 0;
      cnt_mode = 1;
      push(0, 20);
      push(1, 20);
      for (int n = 0; n < 200 && out_words < 12; n++) step();
      check("wrr_class0", tally[0], 9);
      check("wrr_class1", tally[1], 3);
      drain(400);

      // Backpressure in HOLD
      do_init({NC{3'd3}});
      ready_mode = 0;
      push(2, 2);
      wait_valid(30);
      repeat (5) step();
      ready_mode = 1;
      drain(60);

      // Counter collision on class 0
      do_init({NC{3'd1}});
      cnt_mode = 2; cnt_fix = 0;
      push(0, 6);
      drain(100);

      // Randomized rounds
      for (int r = 0; r < 8; r++) begin
         do_init((NC*WW)'($urandom));
         ready_mode = 2;
         cnt_mode   = 1;
         for (int k = 0; k < 4; k++) push(int'($urandom_range(0, NC - 1)), int'($urandom_range(0, 6)));
         drain(600);
      end

      // Counter saturation
      do_init({NC{3'd7}});
      ready_mode = 1;
      cnt_mode   = 1;
      push(0, 300);
      drain(2500);
      cnt_mode = 2; cnt_fix = 0;
      step();
      step();
      check("sat_255", bus.CNT_DATA, CMAX);
      cnt_mode = 0;
      step();

      // Reset while a word sits in HOLD
      do_init({NC{3'd1}});
      ready_mode = 0;
      push(3, 3);
      wait_valid(30);
      repeat (2) step();
      #1 rst = 1'b1;
      #1 reset_checks();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.CNT_REQ = 1'b0;
      model_reset();
      repeat (10) step();
      ready_mode = 1;
      do_init({NC{3'd1}});
      drain(100);
      check("left_after_reset", fq[3].size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
